// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
package wb_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] address;
      logic [XLEN-1:0]   value;
   } wb_req_t;

   typedef enum logic {
      WB_SRC_ALU,
      WB_SRC_LD
   } wb_src_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester, write-port and hazard-query signals of the writeback arbiter.
interface regfile_wb_arbiter_if;
   import wb_pkg::*;

   logic              alu_valid;
   logic              alu_ready;
   logic [REG_AW-1:0] alu_address;
   logic [XLEN-1:0]   alu_value;
   logic              ld_valid;
   logic              ld_ready;
   logic [REG_AW-1:0] ld_address;
   logic [XLEN-1:0]   ld_value;
   logic              save_enable;
   logic [REG_AW-1:0] save_address;
   logic [XLEN-1:0]   save_value;
   logic [REG_AW-1:0] query_address;
   logic              query_pending;
   logic              busy;

   modport master (
      output alu_valid, alu_address, alu_value,
      output ld_valid, ld_address, ld_value,
      output query_address,
      input  alu_ready, ld_ready,
      input  save_enable, save_address, save_value,
      input  query_pending, busy
   );

   modport slave (
      input  alu_valid, alu_address, alu_value,
      input  ld_valid, ld_address, ld_value,
      input  query_address,
      output alu_ready, ld_ready,
      output save_enable, save_address, save_value,
      output query_pending, busy
   );
endinterface

// File: rtl/wb_slot.sv
// One-entry writeback buffer with ready logic and a relative-age bit.
module wb_slot
   import wb_pkg::*;
#(
   parameter bit TIE_OLDER = 1'b0
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    i_valid,
   input  wb_req_t i_req,
   input  logic    i_grant,
   input  logic    i_other_acc,
   output logic    o_ready,
   output logic    o_acc,
   output logic    o_valid,
   output logic    o_older,
   output wb_req_t o_req
);
   logic    r_valid;
   logic    r_older;
   wb_req_t r_req;

   assign o_ready = !rst && (!r_valid || i_grant);
   assign o_acc   = i_valid && o_ready;
   assign o_valid = r_valid;
   assign o_older = r_older;
   assign o_req   = r_req;

   // A fresh entry is younger than anything still pending; TIE_OLDER breaks
   // a simultaneous arrival.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_older <= 1'b0;
         r_req   <= '0;
      end else if (o_acc) begin
         r_valid <= 1'b1;
         r_req   <= i_req;
         r_older <= i_other_acc && TIE_OLDER;
      end else if (i_grant) begin
         r_valid <= 1'b0;
         r_older <= 1'b0;
      end else if (r_valid && i_other_acc) begin
         r_older <= 1'b1;
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writebacks.
module regfile_wb_arbiter
   import wb_pkg::*;
#(
   parameter int STARVE_LIMIT = 3
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

   wb_req_t w_alu_in, w_ld_in, w_alu_q, w_ld_q, w_win;
   logic    w_alu_valid, w_ld_valid, w_alu_older, w_ld_older;
   logic    w_alu_acc, w_ld_acc, w_g_alu, w_g_ld, w_same;
   wb_src_t w_src;

   logic [2:0]        r_starve_cnt;
   logic              r_save_en;
   logic [REG_AW-1:0] r_save_addr;
   logic [XLEN-1:0]   r_save_val;

   assign w_alu_in = '{address: bus.alu_address, value: bus.alu_value};
   assign w_ld_in  = '{address: bus.ld_address, value: bus.ld_value};

   wb_slot #(.TIE_OLDER(1'b0)) u_alu (
      .clk(clk), .rst(rst),
      .i_valid(bus.alu_valid), .i_req(w_alu_in),
      .i_grant(w_g_alu), .i_other_acc(w_ld_acc),
      .o_ready(bus.alu_ready), .o_acc(w_alu_acc),
      .o_valid(w_alu_valid), .o_older(w_alu_older),
      .o_req(w_alu_q)
   );

   wb_slot #(.TIE_OLDER(1'b1)) u_ld (
      .clk(clk), .rst(rst),
      .i_valid(bus.ld_valid), .i_req(w_ld_in),
      .i_grant(w_g_ld), .i_other_acc(w_alu_acc),
      .o_ready(bus.ld_ready), .o_acc(w_ld_acc),
      .o_valid(w_ld_valid), .o_older(w_ld_older),
      .o_req(w_ld_q)
   );

   assign w_same = (w_alu_q.address == w_ld_q.address)
                && (w_ld_q.address != '0);

   always_comb begin
      w_g_alu = 1'b0;
      w_g_ld  = 1'b0;
      if (w_alu_valid && w_ld_valid) begin
         if (w_same) begin
            w_g_ld  = w_ld_older && !w_alu_older;
            w_g_alu = !w_g_ld;
         end else if (r_starve_cnt == LIM) begin
            w_g_alu = 1'b1;
         end else begin
            w_g_ld = 1'b1;
         end
      end else begin
         w_g_alu = w_alu_valid;
         w_g_ld  = w_ld_valid;
      end
   end

   assign w_src = w_g_ld ? WB_SRC_LD : WB_SRC_ALU;
   assign w_win = (w_src == WB_SRC_LD) ? w_ld_q : w_alu_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (w_alu_valid && !w_g_alu) begin
         if (r_starve_cnt != LIM)
            r_starve_cnt <= r_starve_cnt + 3'd1;
      end else begin
         r_starve_cnt <= '0;
      end
   end

   // x0 writes still win arbitration but never reach the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_save_en   <= 1'b0;
         r_save_addr <= '0;
         r_save_val  <= '0;
      end else if (w_g_alu || w_g_ld) begin
         r_save_en   <= (w_win.address != '0);
         r_save_addr <= w_win.address;
         r_save_val  <= w_win.value;
      end else begin
         r_save_en <= 1'b0;
      end
   end

   assign bus.save_enable  = r_save_en;
   assign bus.save_address = r_save_addr;
   assign bus.save_value   = r_save_val;
   assign bus.busy         = w_alu_valid || w_ld_valid || r_save_en;

   assign bus.query_pending = (bus.query_address != '0) && (
        (w_alu_valid && (w_alu_q.address == bus.query_address))
     || (w_ld_valid && (w_ld_q.address == bus.query_address))
     || (r_save_en && (r_save_addr == bus.query_address)));
endmodule
